// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern type, blank pattern and the 16-entry hex font.
// Segment A is bit 6 and segment G is bit 0; all segments are active-high.
package seg7_pkg;

  typedef logic [6:0] seg7_pattern_t;

  localparam seg7_pattern_t SEG7_BLANK   = 7'h00;
  localparam seg7_pattern_t SEG7_GLYPH_0 = 7'h7E;
  localparam seg7_pattern_t SEG7_GLYPH_1 = 7'h30;
  localparam seg7_pattern_t SEG7_GLYPH_2 = 7'h6D;
  localparam seg7_pattern_t SEG7_GLYPH_3 = 7'h79;
  localparam seg7_pattern_t SEG7_GLYPH_4 = 7'h33;
  localparam seg7_pattern_t SEG7_GLYPH_5 = 7'h5B;
  localparam seg7_pattern_t SEG7_GLYPH_6 = 7'h5F;
  localparam seg7_pattern_t SEG7_GLYPH_7 = 7'h70;
  localparam seg7_pattern_t SEG7_GLYPH_8 = 7'h7F;
  localparam seg7_pattern_t SEG7_GLYPH_9 = 7'h7B;
  localparam seg7_pattern_t SEG7_GLYPH_A = 7'h77;
  localparam seg7_pattern_t SEG7_GLYPH_B = 7'h1F;
  localparam seg7_pattern_t SEG7_GLYPH_C = 7'h4E;
  localparam seg7_pattern_t SEG7_GLYPH_D = 7'h3D;
  localparam seg7_pattern_t SEG7_GLYPH_E = 7'h4F;
  localparam seg7_pattern_t SEG7_GLYPH_F = 7'h47;

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse font lookup: segment pattern -> {hit, nibble}.
// hit_o is low for any pattern outside the hex font, including blank.
module seg7_glyph_lookup
  import seg7_pkg::*;
(
  input  seg7_pattern_t pattern_i,
  output logic          hit_o,
  output logic [3:0]    nibble_o
);

  always_comb begin
    hit_o    = 1'b1;
    nibble_o = 4'h0;
    case (pattern_i)
      SEG7_GLYPH_0: nibble_o = 4'h0;
      SEG7_GLYPH_1: nibble_o = 4'h1;
      SEG7_GLYPH_2: nibble_o = 4'h2;
      SEG7_GLYPH_3: nibble_o = 4'h3;
      SEG7_GLYPH_4: nibble_o = 4'h4;
      SEG7_GLYPH_5: nibble_o = 4'h5;
      SEG7_GLYPH_6: nibble_o = 4'h6;
      SEG7_GLYPH_7: nibble_o = 4'h7;
      SEG7_GLYPH_8: nibble_o = 4'h8;
      SEG7_GLYPH_9: nibble_o = 4'h9;
      SEG7_GLYPH_A: nibble_o = 4'hA;
      SEG7_GLYPH_B: nibble_o = 4'hB;
      SEG7_GLYPH_C: nibble_o = 4'hC;
      SEG7_GLYPH_D: nibble_o = 4'hD;
      SEG7_GLYPH_E: nibble_o = 4'hE;
      SEG7_GLYPH_F: nibble_o = 4'hF;
      default:      hit_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Recovers a hex nibble from a 7-segment drive pattern once it has been stable long enough.
// Define SEVEN_SEGMENT_DECODER_INPUT_SYNC_EN to add a two-flop input synchronizer.
module seven_segment_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Blank
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StSettling, StLocked} state_e;

  seg7_pattern_t   raw;
  seg7_pattern_t   sample;
  seg7_pattern_t   pattern_q;
  logic [CntW-1:0] count_q;
  state_e          state_q;
  logic            glyph_hit;
  logic [3:0]      glyph_nibble;

  assign raw = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                i_Segment_E, i_Segment_F, i_Segment_G};

`ifdef SEVEN_SEGMENT_DECODER_INPUT_SYNC_EN
  seg7_pattern_t sync1_q;
  seg7_pattern_t sync2_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= SEG7_BLANK;
      sync2_q <= SEG7_BLANK;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = raw;
`endif

  // Classification uses the registered pattern: on the accepting edge it equals the sample.
  seg7_glyph_lookup u_lookup (
    .pattern_i (pattern_q),
    .hit_o     (glyph_hit),
    .nibble_o  (glyph_nibble)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pattern_q    <= SEG7_BLANK;
      count_q      <= '0;
      state_q      <= StLocked;
      o_Binary_Num <= 4'h0;
      o_Valid      <= 1'b0;
      o_Error      <= 1'b0;
      o_Blank      <= 1'b1;
    end else begin
      o_Valid <= 1'b0;
      if (sample != pattern_q) begin
        pattern_q <= sample;
        count_q   <= '0;
        state_q   <= StSettling;
        o_Blank   <= 1'b0;
      end else if (state_q == StSettling) begin
        if (count_q == CntLast) begin
          state_q <= StLocked;
          if (pattern_q == SEG7_BLANK) begin
            o_Blank <= 1'b1;
          end else begin
            o_Valid <= 1'b1;
            o_Error <= ~glyph_hit;
            if (glyph_hit) o_Binary_Num <= glyph_nibble;
          end
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench for seven_segment_decoder against a run-length reference model.
module tb_seven_segment_decoder;

  localparam int unsigned STABLE = 4;
`ifdef SEVEN_SEGMENT_DECODER_INPUT_SYNC_EN
  localparam int LAT = int'(STABLE) + 3;
`else
  localparam int LAT = int'(STABLE) + 1;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg   = 7'h00;
  logic [3:0] num;
  logic       valid, err, blank;

  always #5 clk = ~clk;

  seven_segment_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Segment_A  (seg[6]),
    .i_Segment_B  (seg[5]),
    .i_Segment_C  (seg[4]),
    .i_Segment_D  (seg[3]),
    .i_Segment_E  (seg[2]),
    .i_Segment_F  (seg[1]),
    .i_Segment_G  (seg[0]),
    .o_Binary_Num (num),
    .o_Valid      (valid),
    .o_Error      (err),
    .o_Blank      (blank)
  );

  logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a pattern is accepted once it has been seen on STABLE+1 consecutive edges.
  logic [6:0] m_prev;
  int         m_run;
  logic       m_valid, m_err, m_blank;
  logic [3:0] m_num;
  logic [6:0] m_pipe [2];

  function automatic int font_index(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (font[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 7'h00; m_run = 1000;
    m_valid = 1'b0; m_err = 1'b0; m_blank = 1'b1; m_num = 4'h0;
    m_pipe[0] = 7'h00; m_pipe[1] = 7'h00;
  endtask

  task automatic apply(input logic [6:0] p);
    logic [6:0] s;
    int idx;
    seg = p;
    @(posedge clk);
`ifdef SEVEN_SEGMENT_DECODER_INPUT_SYNC_EN
    s = m_pipe[1]; m_pipe[1] = m_pipe[0]; m_pipe[0] = p;
`else
    s = p;
`endif
    m_valid = 1'b0;
    if (s != m_prev) begin
      m_prev = s; m_run = 1; m_blank = 1'b0;
    end else if (m_run < 1000) begin
      m_run++;
    end
    if (m_run == int'(STABLE) + 1) begin
      idx = font_index(s);
      if (s == 7'h00) m_blank = 1'b1;
      else if (idx >= 0) begin m_valid = 1'b1; m_num = 4'(idx); m_err = 1'b0; end
      else begin m_valid = 1'b1; m_err = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    #2 rst_n = 1'b0;
    seg = 7'h00;
    model_reset();
    #1;
    n_checks++;
    if ({valid, err, blank, num} !== 7'b0010000)
      $display("FAIL reset_values: got v=%b e=%b b=%b n=%h, want v=0 e=0 b=1 n=0",
               valid, err, blank, num);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) begin
      apply(7'h00);
      if (valid !== 1'b0 || blank !== 1'b1 || num !== 4'h0 || err !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL blank_hold: got %0d bad cycles, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_glyph_sweep();
    int strobes, at, mism;
    logic [3:0] snum;
    logic serr;
    mism = 0;
    for (int g = 0; g < 16; g++) begin
      strobes = 0; at = -1; snum = 4'h0; serr = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        apply(font[g]);
        if ({valid, err, blank, num} !== {m_valid, m_err, m_blank, m_num}) mism++;
        if (valid === 1'b1) begin strobes++; at = k; snum = num; serr = err; end
      end
      n_checks++;
      if (strobes != 1 || at != LAT || snum !== g[3:0] || serr !== 1'b0)
        $display("FAIL sweep_glyph_%0h: got strobes=%0d edge=%0d num=%h err=%b, want 1/%0d/%h/0",
                 g, strobes, at, snum, serr, LAT, g[3:0]);
      else n_pass++;
    end
    n_checks++;
    if (mism != 0) $display("FAIL sweep_model: got %0d mismatching cycles, want 0", mism);
    else n_pass++;
  endtask

  task automatic test_abandon();
    int strobes, bad;
    logic [3:0] snum;
    strobes = 0; bad = 0; snum = 4'h0;
    repeat (3) begin
      apply(7'h6D);
      if (valid !== 1'b0) bad++;
    end
    repeat (10) begin
      apply(7'h79);
      if (valid === 1'b1) begin strobes++; snum = num; end
    end
    n_checks++;
    if (bad != 0 || strobes != 1 || snum !== 4'h3)
      $display("FAIL abandon: got early=%0d strobes=%0d num=%h, want 0/1/3", bad, strobes, snum);
    else n_pass++;
  endtask

  task automatic test_error();
    int strobes;
    logic serr;
    logic [3:0] snum;
    repeat (8) apply(7'h5B);
    n_checks++;
    if (num !== 4'h5 || err !== 1'b0) $display("FAIL error_pre: got num=%h err=%b, want 5/0", num, err);
    else n_pass++;
    strobes = 0; serr = 1'b0; snum = 4'h0;
    repeat (8) begin
      apply(7'h01);
      if (valid === 1'b1) begin strobes++; serr = err; snum = num; end
    end
    n_checks++;
    if (strobes != 1 || serr !== 1'b1 || snum !== 4'h5)
      $display("FAIL error_flag: got strobes=%0d err=%b num=%h, want 1/1/5", strobes, serr, snum);
    else n_pass++;
    repeat (8) apply(7'h30);
    n_checks++;
    if ({valid, err, blank, num} !== 7'b0000001)
      $display("FAIL error_clear: got v=%b e=%b b=%b n=%h, want v=0 e=0 b=0 n=1",
               valid, err, blank, num);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    s1 = 0; s2 = 0;
    repeat (8) begin apply(7'h30); if (valid === 1'b1) s1++; end
    repeat (2) apply(7'h33);
    repeat (8) begin apply(7'h30); if (valid === 1'b1 && num === 4'h1) s2++; end
    n_checks++;
    if (s1 != 0 || s2 != 1)
      $display("FAIL represent: got held=%0d again=%0d strobes, want 0/1", s1, s2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_settle();
    int strobes, at;
    logic [3:0] snum;
    strobes = 0; at = -1; snum = 4'h0;
    repeat (3) apply(7'h77);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({valid, err, blank, num} !== 7'b0010000)
      $display("FAIL mid_reset: got v=%b e=%b b=%b n=%h, want v=0 e=0 b=1 n=0",
               valid, err, blank, num);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      apply(7'h77);
      if (valid === 1'b1) begin strobes++; at = k; snum = num; end
    end
    n_checks++;
    if (strobes != 1 || at != LAT || snum !== 4'hA)
      $display("FAIL after_reset: got strobes=%0d edge=%0d num=%h, want 1/%0d/A",
               strobes, at, snum, LAT);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] p;
    int hold;
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0, 1:    p = font[$urandom_range(0, 15)];
        2:       p = 7'h00;
        default: p = 7'($urandom);
      endcase
      hold = int'($urandom_range(1, 8));
      repeat (hold) begin
        apply(p);
        n_checks++;
        if ({valid, err, blank, num} !== {m_valid, m_err, m_blank, m_num})
          $display("FAIL random pat=%h: got v=%b e=%b b=%b n=%h, want v=%b e=%b b=%b n=%h",
                   p, valid, err, blank, num, m_valid, m_err, m_blank, m_num);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glyph_sweep();
    test_abandon();
    test_error();
    test_back_to_back();
    test_reset_mid_settle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Inverse of the team's nibble-to-7-segment encoder: observes a 7-segment drive pattern (A..G, active-high) and recovers the 4-bit hex value.
- Pattern must hold stable for a programmable number of cycles before it is decoded; glitches during digit transitions are rejected.
- Used for board-level loopback self-test and for snooping the display bus; emits a one-cycle valid strobe per accepted pattern.
- Flags patterns outside the 16-entry hex font, and blank displays.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required after a change before decode (legal range 1..255).

Ports:
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Segment_A .. i_Segment_G  in  1 each  segment drive, active-high; A is the MSB of the 7-bit pattern, G is the LSB.
- o_Binary_Num  out  4  last successfully decoded nibble.
- o_Valid  out  1  one-cycle strobe: a pattern was accepted (hex or error).
- o_Error  out  1  last accepted pattern was not a hex glyph.
- o_Blank  out  1  the stable pattern is 7'h00 (display dark).

Behaviour:
- Reset (async assert, sync release): o_Binary_Num=0, o_Valid=0, o_Error=0, o_Blank=1, pattern register=7'h00, counter=0, state=LOCKED.
- Decode font (pattern->nibble): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F. Every other non-zero pattern is an error.
- States: SETTLING, LOCKED.
- Any state, sample != pattern register: load the sample, counter=0, state=SETTLING, o_Blank=0.
- SETTLING, sample equal, counter<STABLE_CYCLES-1: counter++.
- SETTLING, sample equal, counter==STABLE_CYCLES-1: state=LOCKED, then the accepted pattern is classified:
  - 7'h00: o_Blank=1; no o_Valid; o_Binary_Num and o_Error unchanged.
  - hex glyph: o_Valid=1 for one cycle, o_Binary_Num=decoded value, o_Error=0.
  - other: o_Valid=1 for one cycle, o_Error=1, o_Binary_Num holds its previous value.
- LOCKED, sample equal: hold all outputs, no further strobes.
- Counter width: $clog2(STABLE_CYCLES+1). The counter never wraps; it is cleared on every change.
- Latency: a pattern first present before edge E1 and held produces o_Valid in the cycle after edge E(STABLE_CYCLES+1). With STABLE_CYCLES=4, o_Valid is high after the 5th edge.
- A change that lands on the final settling edge restarts settling; no strobe is emitted for the abandoned pattern.
- Re-presenting the same glyph after an intervening different pattern produces a new strobe.
- Reset mid-settle discards the pending pattern immediately; all outputs return to reset values.

Optional Feature:
- Macro: SEVEN_SEGMENT_DECODER_INPUT_SYNC_EN.
- Defined: a two-flop synchronizer on all seven inputs, reset to 0. Total latency becomes STABLE_CYCLES+3 edges. The synchronizer is required for direct pin inputs.
- Undefined: inputs are sampled directly and must already be synchronous to i_Clk.

Decomposition:
- Package seg7_pkg holds:
  - the 16 glyph constants SEG7_GLYPH_0 .. SEG7_GLYPH_F;
  - SEG7_BLANK = 7'h00;
  - the 7-bit segment pattern typedef.
- The team encoder should migrate to these constants.
- One sub-module, seg7_glyph_lookup: combinational pattern -> {hit, nibble}, instantiated once.

Test Plan:
- Reset then hold 7'h00 for 20 cycles -> o_Blank=1, o_Valid never asserts, o_Binary_Num=0.
- Sweep the 16 glyphs (7E..47), each held 8 cycles, STABLE_CYCLES=4 -> one o_Valid per glyph on the 5th edge, o_Binary_Num=0..F in order, o_Error=0.
- Apply 6D for 3 cycles, then 79 for 10 cycles -> no strobe for 2, one strobe with o_Binary_Num=3.
- Decode 5, then apply 7'h01 held -> o_Valid with o_Error=1, o_Binary_Num stays 5. Then apply 30 -> o_Error=0, o_Binary_Num=1.
- Assert i_Rst_L low on the 3rd settling cycle of 77 -> outputs at reset values asynchronously. After release, 77 held -> strobe after 5 edges with A.
- With SEVEN_SEGMENT_DECODER_INPUT_SYNC_EN defined, apply 7F -> o_Valid after 7 edges with o_Binary_Num=8.
